// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the program counter and runs one instruction-memory
// read at a time through a two-state handshake with a bounded wait for mem_ack.
module instruction_fetch_unit #(
  parameter logic [63:0] PC_RESET = 64'h0,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        IL,
  input  logic [1:0]  PS,
  input  logic        PCsel,
  input  logic [63:0] K,
  input  logic [63:0] reg_data,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instruction,
  output logic [63:0] pc,
  output logic        busy,
  output logic        fetch_done,
  output logic        fetch_error,
  output logic        misalign
);

  typedef enum logic [0:0] {IDLE = 1'b0, WAIT = 1'b1} state_t;

  // Wait-cycle limit narrowed to the counter width (legal range is 1..255)
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t      state_r;
  logic [63:0] pc_r;
  logic [63:0] mem_addr_r;
  logic [31:0] instruction_r;
  logic        mem_req_r;
  logic        busy_r;
  logic        fetch_done_r;
  logic        fetch_error_r;
  logic        misalign_r;
  logic [7:0]  wait_cnt_r;

  logic [63:0] next_pc_s;
  logic [7:0]  wait_cnt_inc_s;
  logic        unused_k_s;

  // Branch displacement: word offset from K, sign-extended and scaled to bytes
  function automatic logic [63:0] branch_offset(input logic sel, input logic [63:0] k);
    logic [63:0] off;
    if (sel == 1'b1) begin
      off = {{43{k[18]}}, k[18:0], 2'b00};
    end else begin
      off = {{36{k[25]}}, k[25:0], 2'b00};
    end
    return off;
  endfunction

  // Only the low offset field of K is meaningful to this block
  assign unused_k_s = ^K[63:26];

  // Candidate PC for this cycle; all arithmetic wraps modulo 2^64
  always_comb begin
    next_pc_s      = pc_r;
    wait_cnt_inc_s = wait_cnt_r + 8'd1;
    case (PS)
      2'b00:   next_pc_s = pc_r;
      2'b01:   next_pc_s = pc_r + 64'd4;
      2'b10:   next_pc_s = pc_r + branch_offset(PCsel, K);
      2'b11:   next_pc_s = {reg_data[63:2], 2'b00};
      default: next_pc_s = pc_r;
    endcase
  end

  // Fetch FSM: PC update and fetch launch in IDLE, ack/timeout handling in WAIT
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r       <= IDLE;
      pc_r          <= PC_RESET;
      mem_addr_r    <= 64'h0;
      instruction_r <= 32'h0;
      mem_req_r     <= 1'b0;
      busy_r        <= 1'b0;
      fetch_done_r  <= 1'b0;
      fetch_error_r <= 1'b0;
      misalign_r    <= 1'b0;
      wait_cnt_r    <= 8'd0;
    end else begin
      fetch_done_r  <= 1'b0;
      fetch_error_r <= 1'b0;
      case (state_r)
        IDLE: begin
          pc_r <= next_pc_s;
          if ((PS == 2'b11) && (reg_data[1:0] != 2'b00)) begin
            misalign_r <= 1'b1;
          end
          if (IL) begin
            // Fetch address is the PC as it stood before this edge
            mem_addr_r <= pc_r;
            mem_req_r  <= 1'b1;
            wait_cnt_r <= 8'd0;
            busy_r     <= 1'b1;
            state_r    <= WAIT;
          end
        end
        WAIT: begin
          if (mem_ack) begin
            // An ack arriving on the timeout edge still delivers its data
            instruction_r <= mem_rdata;
            mem_req_r     <= 1'b0;
            fetch_done_r  <= 1'b1;
            busy_r        <= 1'b0;
            state_r       <= IDLE;
          end else if (wait_cnt_inc_s >= TIMEOUT_C) begin
            instruction_r <= 32'h0;
            mem_req_r     <= 1'b0;
            fetch_error_r <= 1'b1;
            busy_r        <= 1'b0;
            wait_cnt_r    <= wait_cnt_inc_s;
            state_r       <= IDLE;
          end else begin
            wait_cnt_r <= wait_cnt_inc_s;
          end
        end
        default: begin
          mem_req_r <= 1'b0;
          busy_r    <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

  assign pc          = pc_r;
  assign mem_addr    = mem_addr_r;
  assign instruction = instruction_r;
  assign mem_req     = mem_req_r;
  assign busy        = busy_r;
  assign fetch_done  = fetch_done_r;
  assign fetch_error = fetch_error_r;
  assign misalign    = misalign_r;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a transaction-level model predicts
// every output each cycle, and literal checks pin the model at key points.
module tb_instruction_fetch_unit;

  localparam int TO = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        IL = 1'b0;
  logic [1:0]  PS = 2'b00;
  logic        PCsel = 1'b0;
  logic [63:0] K = 64'h0;
  logic [63:0] reg_data = 64'h0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic [31:0] instruction;
  logic [63:0] pc;
  logic        busy;
  logic        fetch_done;
  logic        fetch_error;
  logic        misalign;

  int n_cmp = 0;
  int n_bad = 0;
  int req_cycles;

  // Model state: what the outputs must be after the most recent edge
  logic [63:0] m_pc, m_addr;
  logic [31:0] m_instr;
  bit          m_req, m_busy, m_done, m_err, m_mis;
  int          m_waited;

  instruction_fetch_unit #(.PC_RESET(64'h0), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .IL(IL), .PS(PS), .PCsel(PCsel), .K(K),
    .reg_data(reg_data), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .instruction(instruction),
    .pc(pc), .busy(busy), .fetch_done(fetch_done), .fetch_error(fetch_error),
    .misalign(misalign)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 64'h0; m_addr = 64'h0; m_instr = 32'h0;
    m_req = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0; m_mis = 1'b0;
    m_waited = 0;
  endtask

  // Predict the effect of the coming rising edge from the inputs now applied
  task automatic model_step();
    longint off;
    if (!reset) begin
      model_reset();
    end else begin
      m_done = 1'b0;
      m_err  = 1'b0;
      if (!m_busy) begin
        if (IL) begin
          m_addr = m_pc; m_req = 1'b1; m_busy = 1'b1; m_waited = 0;
        end
        if (PS == 2'd1) m_pc = m_pc + 64'd4;
        else if (PS == 2'd2) begin
          off = PCsel ? longint'($signed(K[18:0])) : longint'($signed(K[25:0]));
          m_pc = m_pc + 64'(off * 4);
        end else if (PS == 2'd3) begin
          m_pc = reg_data & ~64'd3;
          if (reg_data % 4 != 0) m_mis = 1'b1;
        end
      end else if (mem_ack) begin
        m_instr = mem_rdata; m_req = 1'b0; m_busy = 1'b0; m_done = 1'b1;
      end else begin
        m_waited++;
        if (m_waited >= TO) begin
          m_instr = 32'h0; m_req = 1'b0; m_busy = 1'b0; m_err = 1'b1;
        end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    @(negedge clock);
    #1;
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clock) begin
    chk("pc", pc, m_pc);
    chk("mem_addr", mem_addr, m_addr);
    chk("instruction", 64'(instruction), 64'(m_instr));
    chk("mem_req", 64'(mem_req), 64'(m_req));
    chk("busy", 64'(busy), 64'(m_busy));
    chk("fetch_done", 64'(fetch_done), 64'(m_done));
    chk("fetch_error", 64'(fetch_error), 64'(m_err));
    chk("misalign", 64'(misalign), 64'(m_mis));
  end

  initial begin
    model_reset();
    reset = 1'b0;
    tick(); tick();
    chk("rst_pc", pc, 64'h0);
    chk("rst_instr", 64'(instruction), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_req", 64'(mem_req), 64'h0);
    reset = 1'b1;

    // Basic fetch, two memory wait cycles
    IL = 1'b1; PS = 2'b01; tick();
    IL = 1'b0; PS = 2'b00; tick();
    chk("done_c2", 64'(fetch_done), 64'h0);
    tick();
    chk("done_c3", 64'(fetch_done), 64'h0);
    mem_ack = 1'b1; mem_rdata = 32'h8B020020; tick();
    chk("done_c4", 64'(fetch_done), 64'h1);
    chk("f1_instr", 64'(instruction), 64'h8B020020);
    chk("f1_pc", pc, 64'h4);
    chk("f1_addr", mem_addr, 64'h0);
    mem_ack = 1'b0; tick();

    // Branch offsets, both formats
    PS = 2'b11; reg_data = 64'h100; tick();
    chk("ld_pc", pc, 64'h100);
    PS = 2'b10; PCsel = 1'b0; K = 64'h0000_0000_03FF_FFFE; tick();
    chk("b26_pc", pc, 64'hF8);
    PS = 2'b11; reg_data = 64'h100; tick();
    PS = 2'b10; PCsel = 1'b1; K = 64'hFFFF_0000_FC00_0010; tick();
    chk("cb19_pc", pc, 64'h140);

    // Wrap-around both directions
    PS = 2'b11; reg_data = 64'hFFFF_FFFF_FFFF_FFFC; tick();
    PS = 2'b01; tick();
    chk("wrap_up", pc, 64'h0);
    PS = 2'b10; PCsel = 1'b1; K = 64'h0000_0000_0007_FFFF; tick();
    chk("wrap_down", pc, 64'hFFFF_FFFF_FFFF_FFFC);

    // Misaligned register target, then a fetch acked on its first WAIT cycle
    PS = 2'b11; reg_data = 64'h203; tick();
    chk("mis_pc", pc, 64'h200);
    chk("mis_flag", 64'(misalign), 64'h1);
    PS = 2'b00; IL = 1'b1; tick();
    IL = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hD503201F; tick();
    chk("fast_done", 64'(fetch_done), 64'h1);
    chk("fast_addr", mem_addr, 64'h200);
    chk("mis_sticky", 64'(misalign), 64'h1);
    mem_ack = 1'b0;

    // IL/PS ignored while busy, then back-to-back fetch
    PS = 2'b11; reg_data = 64'h10; tick();
    PS = 2'b00; IL = 1'b1; tick();
    PS = 2'b01; IL = 1'b1; tick(); tick();
    chk("stall_pc", pc, 64'h10);
    chk("stall_busy", 64'(busy), 64'h1);
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678; IL = 1'b0; PS = 2'b00; tick();
    chk("stall_done", 64'(fetch_done), 64'h1);
    chk("stall_pc2", pc, 64'h10);
    mem_ack = 1'b0; IL = 1'b1; PS = 2'b01; tick();
    chk("b2b_busy", 64'(busy), 64'h1);
    chk("b2b_addr", mem_addr, 64'h10);
    chk("b2b_pc", pc, 64'h14);
    IL = 1'b0; PS = 2'b00;

    // Ack arriving on the timeout edge wins
    tick(); tick(); tick();
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_0001; tick();
    chk("race_done", 64'(fetch_done), 64'h1);
    chk("race_err", 64'(fetch_error), 64'h0);
    chk("race_instr", 64'(instruction), 64'hCAFE_0001);
    mem_ack = 1'b0;

    // Timeout with no ack
    IL = 1'b1; tick();
    IL = 1'b0;
    req_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      req_cycles += int'(mem_req);
      tick();
    end
    chk("to_req_cycles", 64'(req_cycles), 64'd4);
    chk("to_err", 64'(fetch_error), 64'h1);
    chk("to_instr", 64'(instruction), 64'h0);
    chk("to_busy", 64'(busy), 64'h0);
    tick();
    chk("to_err_pulse", 64'(fetch_error), 64'h0);

    // Ack while idle does nothing
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF; tick(); tick();
    chk("idle_ack", 64'(instruction), 64'h0);
    mem_ack = 1'b0;

    // Reset in the middle of a fetch, then a late ack
    IL = 1'b1; PS = 2'b01; tick();
    IL = 1'b0; PS = 2'b00;
    chk("pre_rst_req", 64'(mem_req), 64'h1);
    reset = 1'b0;
    #1;
    chk("arst_pc", pc, 64'h0);
    chk("arst_req", 64'(mem_req), 64'h0);
    chk("arst_addr", mem_addr, 64'h0);
    chk("arst_busy", 64'(busy), 64'h0);
    chk("arst_mis", 64'(misalign), 64'h0);
    model_reset();
    tick();
    reset = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hABCD_0123; tick(); tick();
    chk("late_ack", 64'(instruction), 64'h0);
    mem_ack = 1'b0; tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
